// File: rtl/bldc_commutator.sv
// Six-step BLDC commutation engine: hall synchronisation and glitch filter, latched
// hall fault, signed commutation counter, period-latched PWM and per-phase dead time.
module bldc_commutator #(
    parameter int DUTY_WIDTH      = 9,
    parameter int DEADTIME_CYCLES = 4,
    parameter int HALL_FILTER     = 8,
    parameter int COUNT_WIDTH     = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          direction,
    input  logic                          brake,
    input  logic [DUTY_WIDTH-1:0]         duty_cycle,
    input  logic [2:0]                    hall,
    output logic [2:0]                    phaseH,
    output logic [2:0]                    phaseL,
    output logic                          fault,
    output logic signed [COUNT_WIDTH-1:0] hall_count
);

    typedef enum logic [1:0] {
        PS_OFF  = 2'd0,
        PS_HIGH = 2'd1,
        PS_LOW  = 2'd2
    } phase_state_t;

    localparam logic [DUTY_WIDTH-1:0] PWM_LAST = {{(DUTY_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [7:0]            FILT_N   = 8'(HALL_FILTER);
    localparam logic [7:0]            DT_LOAD  = 8'(DEADTIME_CYCLES - 1);
    localparam logic [2:0]            IDX_NONE = 3'd7;

    // Position of a hall code in the forward sequence, IDX_NONE for 000/111.
    function automatic logic [2:0] hall_index(input logic [2:0] code);
        case (code)
            3'b101:  hall_index = 3'd0;
            3'b100:  hall_index = 3'd1;
            3'b110:  hall_index = 3'd2;
            3'b010:  hall_index = 3'd3;
            3'b011:  hall_index = 3'd4;
            3'b001:  hall_index = 3'd5;
            default: hall_index = IDX_NONE;
        endcase
    endfunction

    function automatic logic [2:0] idx_next(input logic [2:0] idx);
        idx_next = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    endfunction

    function automatic logic [2:0] idx_prev(input logic [2:0] idx);
        idx_prev = (idx == 3'd0) ? 3'd5 : idx - 3'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Forward-table phase numbers, A=0, B=1, C=2.
    function automatic logic [1:0] comm_high(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: comm_high = 2'd0;
            3'd2, 3'd3: comm_high = 2'd1;
            default:    comm_high = 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] comm_low(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd5: comm_low = 2'd1;
            3'd1, 3'd2: comm_low = 2'd2;
            default:    comm_low = 2'd0;
        endcase
    endfunction

    logic [2:0] hall_sync_p0, hall_sync_p1;
    logic [2:0] hall_prev_p2;
    logic [7:0] filt_cnt_p2;
    logic [2:0] hall_acc_p3;
    logic       evt_vld_p3, evt_fwd_p3, evt_rev_p3, evt_bad_p3;

    logic [7:0] run_len;
    logic       accept;
    logic [2:0] new_idx, acc_idx;
    logic       step_fwd, step_rev, step_bad;

    always_comb begin
        run_len  = (hall_sync_p1 == hall_prev_p2) ? sat_inc8(filt_cnt_p2) : 8'd1;
        accept   = (hall_sync_p1 != hall_acc_p3) && (run_len >= FILT_N);
        new_idx  = hall_index(hall_sync_p1);
        acc_idx  = hall_index(hall_acc_p3);
        step_fwd = (acc_idx != IDX_NONE) && (new_idx != IDX_NONE) && (new_idx == idx_next(acc_idx));
        step_rev = (acc_idx != IDX_NONE) && (new_idx != IDX_NONE) && (new_idx == idx_prev(acc_idx));
        // Leaving the 000 reset code is exempt; a jump into 000/111 never is.
        step_bad = (new_idx == IDX_NONE) ||
                   ((hall_acc_p3 != 3'b000) && !step_fwd && !step_rev);
    end

    // p0/p1: synchroniser, p2: stability filter, p3: accepted code and its step class
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hall_sync_p0 <= 3'b000;
            hall_sync_p1 <= 3'b000;
            hall_prev_p2 <= 3'b000;
            filt_cnt_p2  <= 8'd0;
            hall_acc_p3  <= 3'b000;
            evt_vld_p3   <= 1'b0;
            evt_fwd_p3   <= 1'b0;
            evt_rev_p3   <= 1'b0;
            evt_bad_p3   <= 1'b0;
        end else begin
            hall_sync_p0 <= hall;
            hall_sync_p1 <= hall_sync_p0;
            hall_prev_p2 <= hall_sync_p1;
            filt_cnt_p2  <= run_len;
            evt_vld_p3   <= accept;
            evt_fwd_p3   <= accept && step_fwd;
            evt_rev_p3   <= accept && step_rev;
            evt_bad_p3   <= accept && step_bad;
            if (accept) begin
                hall_acc_p3 <= hall_sync_p1;
            end
        end
    end

    // p4: fault latch and commutation counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault      <= 1'b0;
            hall_count <= '0;
        end else begin
            if (!enable) begin
                fault <= 1'b0;
            end else if (evt_vld_p3 && evt_bad_p3) begin
                fault <= 1'b1;
            end
            if (evt_fwd_p3) begin
                hall_count <= hall_count + COUNT_WIDTH'(1);
            end else if (evt_rev_p3) begin
                hall_count <= hall_count - COUNT_WIDTH'(1);
            end
        end
    end

    logic [DUTY_WIDTH-1:0] pwm_cnt, duty_q, duty_eff;
    logic                  pwm_on;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else begin
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + DUTY_WIDTH'(1);
            if (pwm_cnt == '0) begin
                duty_q <= duty_cycle;
            end
        end
    end

    // The boundary cycle itself already uses the incoming duty so every period is whole.
    assign duty_eff = (pwm_cnt == '0) ? duty_cycle : duty_q;
    assign pwm_on   = pwm_cnt < duty_eff;

    logic         drive_ok;
    logic [1:0]   hi_ph, lo_ph;
    phase_state_t req [3];

    // A just-accepted bad step blocks drive now, so outputs drop together with fault.
    assign drive_ok = enable && !fault && !(evt_vld_p3 && evt_bad_p3);

    always_comb begin
        hi_ph = comm_high(acc_idx);
        lo_ph = comm_low(acc_idx);
        if (direction) begin
            hi_ph = comm_low(acc_idx);
            lo_ph = comm_high(acc_idx);
        end
        for (int p = 0; p < 3; p++) begin
            req[p] = PS_OFF;
            if (drive_ok) begin
                if (brake) begin
                    req[p] = PS_LOW;
                end else if (acc_idx != IDX_NONE) begin
                    if (2'(p) == hi_ph) begin
                        req[p] = pwm_on ? PS_HIGH : PS_LOW;
                    end else if (2'(p) == lo_ph) begin
                        req[p] = PS_LOW;
                    end
                end
            end
        end
    end

    phase_state_t tgt [3];
    logic [7:0]   dt_cnt [3];
    logic [2:0]   out_h, out_l;

    // p5: per-phase dead time and registered gate drive
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 3; p++) begin
                tgt[p]    <= PS_OFF;
                dt_cnt[p] <= 8'd0;
            end
            out_h <= 3'b000;
            out_l <= 3'b000;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (req[p] == PS_OFF) begin
                    tgt[p]    <= PS_OFF;
                    dt_cnt[p] <= 8'd0;
                    out_h[p]  <= 1'b0;
                    out_l[p]  <= 1'b0;
                end else if (req[p] != tgt[p]) begin
                    tgt[p]    <= req[p];
                    dt_cnt[p] <= DT_LOAD;
                    out_h[p]  <= 1'b0;
                    out_l[p]  <= 1'b0;
                end else if (dt_cnt[p] != 8'd0) begin
                    dt_cnt[p] <= dt_cnt[p] - 8'd1;
                    out_h[p]  <= 1'b0;
                    out_l[p]  <= 1'b0;
                end else begin
                    out_h[p]  <= (tgt[p] == PS_HIGH);
                    out_l[p]  <= (tgt[p] == PS_LOW);
                end
            end
        end
    end

    assign phaseH = {out_h[0], out_h[1], out_h[2]};
    assign phaseL = {out_l[0], out_l[1], out_l[2]};

endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
Parametrised six-step BLDC commutation engine, one instance per motor. It sits between the raw hall-sensor pins and the gate-driver pins. It adds the following over the previous hall-decode plus phase-driver arrangement:
- hall input synchronisation and glitch filtering
- direction control
- duty latching at PWM period boundaries
- per-phase dead-time insertion
- brake mode
- latched hall-fault detection
- a signed commutation counter for speed/position feedback

Parameters:
DUTY_WIDTH, 9, width of duty_cycle and of the PWM counter
DEADTIME_CYCLES, 4, clocks both switches of a phase are held off on any phase-state change (1..255)
HALL_FILTER, 8, clocks a synchronised hall code must be stable before it is accepted (1..255)
COUNT_WIDTH, 16, width of hall_count

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = drive motor; 0 = all phases float, clears fault
direction  in  1  0 = forward, 1 = reverse
brake  in  1  1 = all low sides on (overrides commutation, not fault/enable)
duty_cycle  in  DUTY_WIDTH  high-side on-time in clocks per PWM period
hall  in  3  raw hall sensors {A,B,C}, asynchronous
phaseH  out  3  high-side gate {A,B,C}
phaseL  out  3  low-side gate {A,B,C}
fault  out  1  latched hall fault
hall_count  out  COUNT_WIDTH  signed accepted-commutation counter

Behaviour:
- Reset (async, reset_n=0): phaseH=0, phaseL=0, fault=0, hall_count=0, PWM counter=0, latched duty=0, accepted hall code=000, dead-time counters=0, filter counter=0. All outputs are registered.
- Hall path: 2-flop synchroniser, then a stability counter. A code differing from the accepted code is accepted after HALL_FILTER consecutive identical synchronised samples. Any change restarts the count. Raw change to accepted code takes 2+HALL_FILTER clocks.
- Forward sequence: 101→100→110→010→011→001→101.
- Accepted transition one step forward: hall_count+1. One step backward: hall_count−1. Arithmetic is two's complement and wraps.
- Fault conditions (fault latched to 1 the following clock):
  - accepted code 000 or 111
  - accepted transition that is not adjacent in the sequence
  - leaving the 000 reset code is exempt and does not count
- Fault clears only while enable=0. Fault forces all phases to float.
- Commutation table, forward (hall → high phase, low phase; third phase floats): 101→A,B; 100→A,C; 110→B,C; 010→B,A; 011→C,A; 001→C,B.
- Reverse swaps the high and low phases of each table entry.
- PWM counter: free-running 0..2^DUTY_WIDTH−2, then wraps to 0; period is 2^DUTY_WIDTH−1 clocks.
- duty_cycle is latched when the counter equals 0. Mid-period changes have no effect until the next period.
- pwm_on = counter < latched duty. duty=0 means never on; duty=2^DUTY_WIDTH−1 means always on.
- Requested phase state is one of OFF, HIGH or LOW:
  - high phase: HIGH when pwm_on, else LOW (complementary)
  - low phase: LOW
  - float phase: OFF
- Priority: enable=0 or fault → all OFF; else brake → all LOW; else commutation table.
- Dead time, per phase:
  - Output pair is {H,L}: HIGH={1,0}, LOW={0,1}, OFF={0,0}.
  - Any change of the requested state drives {0,0} for DEADTIME_CYCLES clocks, then applies the new state.
  - A request change during dead time restarts the count toward the newest request.
  - Change to OFF applies immediately, with no dead time required.
  - phaseH[i] and phaseL[i] are never both 1, under any input including reset release.
- Nominal latency (no dead time pending): request change → output change = 1 clock.
- enable 1→0 mid-operation: all outputs are 0 on the next clock, and the PWM counter keeps running.

Test Plan:
- Reset: hold reset_n=0 with hall=101, enable=1, duty=100 → all outputs 0. Release → no gate asserted before the hall filter settles, then phase A high-side PWM and phase B low side on, after DEADTIME_CYCLES.
- Forward rotation: step hall 101→100→110→010→011→001→101, each held 50 clocks, direction=0 → hall_count=+6, drive pairs match the table, fault=0. Same with direction=1 and reverse order → hall_count=−6, high/low swapped.
- Glitch: 3-clock pulse 101→100→101 with HALL_FILTER=8 → no accepted change, hall_count unchanged, outputs unchanged.
- Dead time: duty=255 (DUTY_WIDTH=9) → on the high phase, every H↔L toggle is separated by exactly 4 clocks of {0,0}. Checker over 10 periods: never H=L=1.
- Fault: accepted jump 101→010 → fault=1 and all outputs 0 on the next clock. enable=0 for 1 clock, then enable=1 → fault=0 and drive resumes.
- Duty latch and brake: change duty 50→200 mid-period → high time stays 50 until the counter wraps. Assert brake → phaseL=111 and phaseH=000 after the dead time.
